// File: rtl/uart_tx_parity.sv
// UART transmit serializer: start bit, LSB-first data, even parity, one stop bit.
// Each bit is held for CLKS_PER_BIT cycles; words are accepted only in IDLE.
module uart_tx_parity #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int CLKS_PER_BIT     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        serial_out,
   output logic                        tx_busy,
   output logic                        is_parity_stage
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                      state_reg;
   logic [INPUT_DATA_WIDTH-1:0] shift_reg;
   logic                        parity_reg;
   logic [CNT_W-1:0]            baud_cnt_reg;
   logic [IDX_W-1:0]            bit_idx_reg;
   logic                        serial_reg;
   logic                        parity_stage_reg;

   logic                        bit_end;
   logic [INPUT_DATA_WIDTH-1:0] shift_next;

   assign bit_end    = (baud_cnt_reg == CNT_LAST);
   assign shift_next = shift_reg >> 1;

   assign tx_ready        = (state_reg == IDLE);
   assign tx_busy         = !tx_ready;
   assign serial_out      = serial_reg;
   assign is_parity_stage = parity_stage_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         shift_reg        <= '0;
         parity_reg       <= 1'b0;
         baud_cnt_reg     <= '0;
         bit_idx_reg      <= '0;
         serial_reg       <= 1'b1;
         parity_stage_reg <= 1'b0;
      end else begin
         if (state_reg != IDLE)
            baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + 1'b1;

         case (state_reg)
            IDLE: begin
               if (tx_valid) begin
                  shift_reg    <= tx_data;
                  parity_reg   <= ^tx_data;
                  baud_cnt_reg <= '0;
                  bit_idx_reg  <= '0;
                  serial_reg   <= 1'b0;
                  state_reg    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  serial_reg <= shift_reg[0];
                  state_reg  <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx_reg == IDX_LAST) begin
                     serial_reg       <= parity_reg;
                     parity_stage_reg <= 1'b1;
                     state_reg        <= PARITY;
                  end else begin
                     // Drive the next bit from the shifted value so the line
                     // changes on the same edge as the shift.
                     shift_reg   <= shift_next;
                     serial_reg  <= shift_next[0];
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  serial_reg       <= 1'b1;
                  parity_stage_reg <= 1'b0;
                  state_reg        <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  serial_reg <= 1'b1;
                  state_reg  <= IDLE;
               end
            end
            default: begin
               serial_reg       <= 1'b1;
               parity_stage_reg <= 1'b0;
               state_reg        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: four instances (C=4,1,2,3) share clock and reset;
// expected line bits and words go through queues and are compared as the line produces them.
module tb_uart_tx_parity;

   function automatic int cpb(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         2:       return 2;
         default: return 3;
      endcase
   endfunction

   logic       clk;
   logic       reset;
   logic [3:0] tx_valid;
   logic [7:0] tx_data [4];
   logic [3:0] so_w, rdy_w, busy_w, par_w;

   int total = 0;
   int bad   = 0;

   logic       exp_q  [$];
   logic [7:0] word_q [$];

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      uart_tx_parity #(
         .INPUT_DATA_WIDTH(8),
         .CLKS_PER_BIT    (cpb(gi))
      ) u_dut (
         .clk            (clk),
         .reset          (reset),
         .tx_data        (tx_data[gi]),
         .tx_valid       (tx_valid[gi]),
         .tx_ready       (rdy_w[gi]),
         .serial_out     (so_w[gi]),
         .tx_busy        (busy_w[gi]),
         .is_parity_stage(par_w[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input int i, input string tag);
      chk({tag, "_line"},   32'(so_w[i]),   32'd1);
      chk({tag, "_ready"},  32'(rdy_w[i]),  32'd1);
      chk({tag, "_busy"},   32'(busy_w[i]), 32'd0);
      chk({tag, "_pstage"}, 32'(par_w[i]),  32'd0);
   endtask

   // Called on a negedge with instance i idle; checks every cycle of the frame.
   task automatic frame(input int i, input logic [7:0] d, input bit drive,
                        input bit hold, input logic [7:0] next_d);
      int c;
      logic [10:0] bits;
      c    = cpb(i);
      bits = {1'b1, ^d, d, 1'b0};
      for (int b = 0; b < 11; b++) exp_q.push_back(bits[b]);
      if (drive) begin
         tx_data[i]  = d;
         tx_valid[i] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (hold) tx_data[i] = next_d;
      else begin
         tx_valid[i] = 1'b0;
         tx_data[i]  = 8'($urandom);
      end
      for (int j = 0; j < 11 * c; j++) begin
         chk("line",   32'(so_w[i]),   32'(exp_q[0]));
         chk("pstage", 32'(par_w[i]),  32'(j / c == 9));
         chk("busy",   32'(busy_w[i]), 32'd1);
         chk("ready",  32'(rdy_w[i]),  32'd0);
         if (j % c == c - 1) void'(exp_q.pop_front());
         @(negedge clk);
         if (!hold) tx_data[i] = 8'($urandom);
      end
      chk("ready_after_frame", 32'(rdy_w[i]), 32'd1);
      chk("idle_after_frame",  32'(so_w[i]),  32'd1);
      $display("frame inst=%0d C=%0d data=%02h parity=%0b", i, c, d, ^d);
   endtask

   // Bench deserializer for instance 3 (C=3): sample each bit at its centre.
   task automatic sweep_word(input logic [7:0] d);
      logic [7:0] rx, exp_w;
      logic       st, sp, rx_par;
      int         guard;
      word_q.push_back(d);
      tx_data[3]  = d;
      tx_valid[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid[3] = 1'b0;
      tx_data[3]  = 8'($urandom);
      @(negedge clk);
      st = so_w[3];
      for (int b = 0; b < 8; b++) begin
         repeat (3) @(negedge clk);
         rx[b] = so_w[3];
      end
      repeat (3) @(negedge clk);
      rx_par = so_w[3];
      repeat (3) @(negedge clk);
      sp = so_w[3];
      guard = 0;
      while (!rdy_w[3] && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      chk("sweep_ready", 32'(rdy_w[3]), 32'd1);
      exp_w = word_q.pop_front();
      chk("sweep_start",  32'(st),     32'd0);
      chk("sweep_stop",   32'(sp),     32'd1);
      chk("sweep_word",   32'(rx),     32'(exp_w));
      chk("sweep_parity", 32'(rx_par), 32'(^exp_w));
      $display("sweep word=%02h recovered=%02h parity=%0b", exp_w, rx, rx_par);
   endtask

   initial begin
      reset    = 1'b1;
      tx_valid = 4'hF;
      for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);

      // Reset held 3 cycles with tx_valid high: no frame may start.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) chk_idle(i, "reset");
      end
      reset    = 1'b0;
      tx_valid = 4'h0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk_idle(i, "post_reset");

      // Single frame, C=4.
      frame(0, 8'hA5, 1'b1, 1'b0, 8'h00);

      // Odd-weight word, C=1.
      frame(1, 8'h07, 1'b1, 1'b0, 8'h00);

      // Back-to-back with tx_valid held: exactly one idle cycle between frames.
      frame(2, 8'h00, 1'b1, 1'b1, 8'hFF);
      chk("b2b_ready_one_cycle", 32'(rdy_w[2]), 32'd1);
      frame(2, 8'hFF, 1'b0, 1'b0, 8'h00);

      // Reset mid-frame during data bit 3 of 0x3C.
      tx_data[0]  = 8'h3C;
      tx_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (17) @(negedge clk);
      chk("mid_bit3", 32'(so_w[0]), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_idle(0, "mid_reset");
      reset = 1'b0;
      $display("abort inst=0 data=3c at data bit 3");
      @(negedge clk);
      chk_idle(0, "after_abort");
      frame(0, 8'h81, 1'b1, 1'b0, 8'h00);

      // Randomized sweep, C=3.
      for (int n = 0; n < 200; n++) begin
         sweep_word(8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
